// File: rtl/func_lut_eval.sv
// Programmable N-input boolean function unit: a registered truth-table lookup behind
// valid/ready handshakes, with a serial MSB-first table reload path.
module func_lut_eval #(
    parameter int unsigned            N_IN        = 4,
    parameter logic [2**N_IN-1:0]     RESET_TABLE = 16'hFF7C,
    parameter int unsigned            CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_start,
    input  logic             cfg_valid,
    input  logic             cfg_bit,
    output logic             cfg_done,
    output logic             loading,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_g,
    output logic [CNT_W-1:0] eval_count
);

    localparam int unsigned W = 2 ** N_IN;
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(W - 1);

    if (N_IN < 1 || N_IN > 6) begin : gen_bad_n_in
        $error("func_lut_eval: N_IN must be in 1..6");
    end

    typedef enum logic [0:0] {StRun, StLoad} state_e;

    state_e            state_q;
    logic [W-1:0]      active_q;
    logic [W-1:0]      shadow_q;
    logic [N_IN-1:0]   bit_cnt_q;
    logic              out_valid_q;
    logic              out_g_q;
    logic              cfg_done_q;
    logic [CNT_W-1:0]  eval_count_q;
    logic              accept;

    // A held result blocks new input; LOAD blocks input entirely.
    assign in_ready   = (state_q == StRun) && (!out_valid_q || out_ready);
    assign accept     = in_valid && in_ready;
    assign loading    = (state_q == StLoad);
    assign out_valid  = out_valid_q;
    assign out_g      = out_g_q;
    assign cfg_done   = cfg_done_q;
    assign eval_count = eval_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StRun;
            active_q     <= RESET_TABLE;
            shadow_q     <= '0;
            bit_cnt_q    <= '0;
            out_valid_q  <= 1'b0;
            out_g_q      <= 1'b0;
            cfg_done_q   <= 1'b0;
            eval_count_q <= '0;
        end else begin
            cfg_done_q <= 1'b0;

            if (accept) begin
                out_g_q      <= active_q[in_vec];
                out_valid_q  <= 1'b1;
                eval_count_q <= eval_count_q + CNT_W'(1);
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            unique case (state_q)
                StRun: begin
                    // Only start a load once the output stage is empty.
                    if (cfg_start && !out_valid_q) begin
                        state_q   <= StLoad;
                        bit_cnt_q <= '0;
                        shadow_q  <= '0;
                    end
                end
                StLoad: begin
                    if (cfg_start) begin
                        bit_cnt_q <= '0;
                        shadow_q  <= '0;
                    end else if (cfg_valid) begin
                        shadow_q <= {shadow_q[W-2:0], cfg_bit};
                        if (bit_cnt_q == LAST_IDX) begin
                            active_q   <= {shadow_q[W-2:0], cfg_bit};
                            cfg_done_q <= 1'b1;
                            bit_cnt_q  <= '0;
                            state_q    <= StRun;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + N_IN'(1);
                        end
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

endmodule
